// File: rtl/hs_npu_pkg.sv
// rtl/hs_npu_pkg.sv - shared types for the NPU layer sequencer
// Layer descriptor layout and sequencer state encoding.
package hs_npu_pkg;

   typedef logic [31:0] uword;

   typedef struct packed {
      uword       dim0;
      uword       dim1;
      uword       dim2;
      uword       dim3;
      logic       reuse_inputs;
      logic       reuse_weights;
      logic       save_outputs;
      logic       use_bias;
      logic       use_sum;
      uword       shift_amount;
      logic [3:0] activation_select;
      uword       base_address;
      uword       result_address;
   } layer_desc_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_LAUNCH,
      ST_RUN,
      ST_DRAIN
   } seq_state_e;

   // The NPU holds no valid operands before the first layer of a run,
   // so reuse requests on that layer would read stale buffers.
   function automatic layer_desc_t first_layer_view(input layer_desc_t d);
      layer_desc_t r;
      r               = d;
      r.reuse_inputs  = 1'b0;
      r.reuse_weights = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/hs_npu_desc_fifo.sv
// rtl/hs_npu_desc_fifo.sv - layer descriptor queue with flush
// Flush wins over push and pop in the same cycle.
module hs_npu_desc_fifo
   import hs_npu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  layer_desc_t data_i,
   input  logic        pop_i,
   input  logic        flush_i,
   output layer_desc_t head_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(DEPTH);

   layer_desc_t   mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i && !empty_o && !flush_i;
   // A pop frees the slot the push lands in, so full-with-pop still accepts.
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/hs_npu_layer_sequencer.sv
// rtl/hs_npu_layer_sequencer.sv - queues layer descriptors and issues them to the NPU
// Handshakes one layer at a time, waits for completion, guards with a timeout.
module hs_npu_layer_sequencer
   import hs_npu_pkg::*;
#(
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        desc_valid_i,
   output logic        desc_ready_o,
   input  layer_desc_t desc_i,
   input  logic        start_i,
   input  logic        abort_i,
   output logic        exec_valid_o,
   input  logic        exec_ready_i,
   output layer_desc_t layer_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output uword        layers_done_o
);

   seq_state_e  state_q, state_d;
   layer_desc_t layer_q, layer_d;
   uword        tcnt_q, tcnt_d;
   uword        layers_q, layers_d;
   logic        error_q, error_d;
   logic        done_q, done_d;
   logic        abort_pend_q, abort_pend_d;
   logic        ready_en_q;

   layer_desc_t fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_flush;
   logic        handshake;
   logic        timed_out;

   hs_npu_desc_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  (desc_i),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign desc_ready_o  = ready_en_q && !fifo_full;
   assign fifo_push     = desc_valid_i && desc_ready_o;
   assign exec_valid_o  = (state_q == ST_ISSUE);
   assign handshake     = exec_valid_o && exec_ready_i;
   assign timed_out     = (tcnt_q == uword'(TIMEOUT_CYCLES));
   assign layer_o       = layer_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign layers_done_o = layers_q;

   always_comb begin
      state_d      = state_q;
      layer_d      = layer_q;
      tcnt_d       = '0;
      layers_d     = layers_q;
      error_d      = error_q;
      done_d       = 1'b0;
      abort_pend_d = abort_pend_q;
      fifo_pop     = 1'b0;
      fifo_flush   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            abort_pend_d = 1'b0;
            if (start_i) begin
               error_d  = 1'b0;
               layers_d = '0;
               if (fifo_empty) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
                  layer_d = first_layer_view(fifo_head);
               end
            end
         end

         ST_ISSUE: begin
            // Once the NPU has taken the layer it must be allowed to finish,
            // so a coincident abort is handled as an abort of a running layer.
            if (handshake) begin
               fifo_pop = 1'b1;
               state_d  = ST_LAUNCH;
               if (abort_i) begin
                  fifo_flush   = 1'b1;
                  abort_pend_d = 1'b1;
               end
            end else if (abort_i) begin
               fifo_flush = 1'b1;
               state_d    = ST_IDLE;
            end
         end

         ST_LAUNCH: begin
            tcnt_d  = tcnt_q + 1'b1;
            state_d = ST_RUN;
            if (abort_i) begin
               fifo_flush   = 1'b1;
               abort_pend_d = 1'b1;
            end
         end

         ST_RUN: begin
            tcnt_d = tcnt_q + 1'b1;
            if (abort_i) begin
               fifo_flush   = 1'b1;
               abort_pend_d = 1'b1;
            end
            if (exec_ready_i) begin
               layers_d = layers_q + 1'b1;
               if (abort_i || abort_pend_q || fifo_empty) begin
                  state_d = ST_DRAIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
                  layer_d = fifo_head;
               end
            end else if (timed_out) begin
               error_d    = 1'b1;
               fifo_flush = 1'b1;
               state_d    = ST_IDLE;
            end
         end

         ST_DRAIN: begin
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         layer_q      <= '0;
         tcnt_q       <= '0;
         layers_q     <= '0;
         error_q      <= 1'b0;
         done_q       <= 1'b0;
         abort_pend_q <= 1'b0;
         ready_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         layer_q      <= layer_d;
         tcnt_q       <= tcnt_d;
         layers_q     <= layers_d;
         error_q      <= error_d;
         done_q       <= done_d;
         abort_pend_q <= abort_pend_d;
         ready_en_q   <= 1'b1;
      end
   end

endmodule

// File: doc/hs_npu_layer_sequencer.md
HS_NPU_LAYER_SEQUENCER -- requirements
Module: hs_npu_layer_sequencer

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, descriptor queue entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, max cycles a layer may run before abort.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port desc_valid_i  input  1  CPU offers a layer descriptor.
REQ-006 SHALL have port desc_ready_o  output  1  queue can accept a descriptor.
REQ-007 SHALL have port desc_i  input  layer_desc_t  layer fields: 4 dims, reuse_inputs, reuse_weights, save_outputs, use_bias, use_sum, shift_amount, activation_select, base_address, result_address.
REQ-008 SHALL have port start_i  input  1  pulse; begin executing queued layers.
REQ-009 SHALL have port abort_i  input  1  pulse; stop after flushing queue.
REQ-010 SHALL have port exec_valid_o  output  1  drives NPU exec_valid_i.
REQ-011 SHALL have port exec_ready_i  input  1  from NPU exec_ready_o; high = idle/accepting.
REQ-012 SHALL have port layer_o  output  layer_desc_t  configuration presented to the NPU.
REQ-013 SHALL have port busy_o  output  1  state != IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse when the queue drains normally.
REQ-015 SHALL have port error_o  output  1  sticky; set on timeout, cleared by start_i.
REQ-016 SHALL have port layers_done_o  output  uword  layers completed since last start_i.

Function
REQ-017 Queue SHALL accept on desc_valid_i & desc_ready_o; desc_ready_o = !full; pushes are allowed in any state.
REQ-018 FSM states SHALL be IDLE, ISSUE, LAUNCH, RUN, DRAIN.
REQ-019 IDLE->ISSUE on start_i with queue non-empty; start_i on an empty queue SHALL pulse done_o next cycle and stay IDLE.
REQ-020 ISSUE SHALL assert exec_valid_o with layer_o = queue head; on exec_valid_o & exec_ready_i, pop the head and go to LAUNCH.
REQ-021 layer_o SHALL be registered, hold stable while exec_valid_o is high, and reset to all zeros.
REQ-022 For the first layer after start_i, layer_o.reuse_inputs and layer_o.reuse_weights SHALL be forced to 0.
REQ-023 LAUNCH SHALL last exactly 1 cycle, ignore exec_ready_i, then go to RUN.
REQ-024 RUN SHALL wait for exec_ready_i high, then increment layers_done_o (wraps at 2^32) and go to ISSUE if the queue is non-empty, else DRAIN.
REQ-025 DRAIN SHALL pulse done_o for 1 cycle and return to IDLE.
REQ-026 The timeout counter SHALL clear on entering LAUNCH and count in LAUNCH and RUN; on reaching TIMEOUT_CYCLES it SHALL set error_o, flush the queue, and go to IDLE with no done_o.
REQ-027 abort_i in ISSUE SHALL drop exec_valid_o next cycle, flush the queue, and go to IDLE.
REQ-028 abort_i in LAUNCH or RUN SHALL flush the queue, finish the current layer, then go to DRAIN.
REQ-029 A push coinciding with a flush SHALL be discarded.
REQ-030 A simultaneous push and pop on a full queue SHALL be legal; a simultaneous push and pop on an empty queue SHALL not pop.
REQ-031 start_i while busy_o is high SHALL be ignored.

Reset
REQ-032 While rst is high, the FSM SHALL be IDLE, the queue empty, and the timeout counter 0.
REQ-033 While rst is high, exec_valid_o, done_o, busy_o and error_o SHALL be 0, layers_done_o 0, layer_o zeros, and desc_ready_o 0.
REQ-034 desc_ready_o SHALL rise the first cycle after rst deasserts.
REQ-035 Reset mid-layer SHALL NOT be signalled to the NPU; the NPU shares rst.

Structure
REQ-036 layer_desc_t and the FSM state enum SHALL live in hs_npu_pkg, reusing uword for the address, dimension and shift fields.
REQ-037 The descriptor queue SHALL be a sub-module hs_npu_desc_fifo (parameterised depth, flush input, full/empty outputs).

Verification
REQ-038 Push 3 descriptors, start_i, model NPU busy 10 cycles each -> 3 exec handshakes, layers_done_o=3, one done_o, error_o=0.
REQ-039 Push a descriptor with reuse_inputs=1 as the first layer -> layer_o.reuse_inputs=0 at the handshake.
REQ-040 TIMEOUT_CYCLES=20, NPU never returns ready -> error_o=1 about 21 cycles after the handshake, queue empty, no done_o.
REQ-041 Push 4 (full) -> desc_ready_o=0; pop while pushing -> count stays 4, no data lost.
REQ-042 abort_i during RUN of layer 1 of 3 -> layer 1 completes, layers_done_o=1, done_o pulses, queue empty.
REQ-043 Assert rst mid-RUN -> all outputs at reset values, desc_ready_o=1 the first cycle after rst drops.
